// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the single-issue CPU.
// Owns the PC, the instruction register, write-back gating and branch resolution.
module instr_sequencer #(
  parameter int PC_WIDTH     = 32,
  parameter int RESET_PC     = 0,
  parameter int OFFSET_WIDTH = 8,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [PC_WIDTH-1:0] PC,
  output logic                IMEM_READ,
  input  logic                IMEM_BUSYWAIT,
  input  logic [31:0]         IMEM_RDATA,
  output logic [31:0]         INSTRUCTION,
  input  logic                WRITEENABLE,
  input  logic                BRAZ,
  input  logic                BRANZ,
  input  logic                BRAUNCOND,
  input  logic                ZERO,
  output logic                REG_WRITE_EN,
  output logic                HALTED,
  output logic [1:0]          ERROR,
  output logic [15:0]         INSTR_COUNT
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t                  state;
  logic [WCW-1:0]          wait_cnt;
  logic [WCW-1:0]          wait_nxt;
  logic                    zero_q;
  logic [3:0]              opcode;
  logic                    is_branch;
  logic                    taken;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0]     off_ext;
  logic [PC_WIDTH-1:0]     pc_seq;
  logic [PC_WIDTH-1:0]     pc_tgt;

  // Opcodes 1001..1011 are branches; anything above 1011 is illegal.
  assign opcode    = INSTRUCTION[31:28];
  assign is_branch = (opcode > 4'h8) && (opcode < 4'hC);
  assign taken     = is_branch & (BRAUNCOND | (BRAZ & zero_q) | (BRANZ & ~zero_q));
  assign offset    = INSTRUCTION[OFFSET_WIDTH-1:0];
  assign off_ext   = {{(PC_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
  assign pc_seq    = PC + PC_WIDTH'(4);
  assign pc_tgt    = pc_seq + (off_ext << 2);
  assign wait_nxt  = wait_cnt + WCW'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_FETCH;
      PC           <= PC_WIDTH'(RESET_PC);
      INSTRUCTION  <= '0;
      IMEM_READ    <= 1'b0;
      REG_WRITE_EN <= 1'b0;
      HALTED       <= 1'b0;
      ERROR        <= 2'b00;
      INSTR_COUNT  <= '0;
      wait_cnt     <= '0;
      zero_q       <= 1'b0;
    end else begin
      REG_WRITE_EN <= 1'b0;
      case (state)
        S_FETCH: begin
          IMEM_READ <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (!IMEM_BUSYWAIT) begin
            INSTRUCTION <= IMEM_RDATA;
            IMEM_READ   <= 1'b0;
            state       <= S_DECODE;
          end else if (wait_nxt == WCW'(MEM_TIMEOUT)) begin
            IMEM_READ <= 1'b0;
            HALTED    <= 1'b1;
            ERROR     <= 2'b10;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        S_DECODE: begin
          if (opcode > 4'hB) begin
            HALTED <= 1'b1;
            ERROR  <= 2'b01;
            state  <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Branches never write the register file, even with WRITEENABLE unknown.
          zero_q       <= ZERO;
          REG_WRITE_EN <= !is_branch && (WRITEENABLE === 1'b1);
          state        <= S_WB;
        end
        S_WB: begin
          PC          <= taken ? pc_tgt : pc_seq;
          INSTR_COUNT <= INSTR_COUNT + 16'd1;
          state       <= S_FETCH;
        end
        default: begin
          IMEM_READ <= 1'b0;
          state     <= S_HALT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: small instruction memory with programmable
// BUSYWAIT stall, one task per scenario with hand-computed expectations.
module tb_instr_sequencer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC;
  logic        IMEM_READ;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION;
  logic        WRITEENABLE = 1'b0;
  logic        BRAZ = 1'b0;
  logic        BRANZ = 1'b0;
  logic        BRAUNCOND = 1'b0;
  logic        ZERO = 1'b0;
  logic        REG_WRITE_EN;
  logic        HALTED;
  logic [1:0]  ERROR;
  logic [15:0] INSTR_COUNT;

  int errors = 0;
  int checks = 0;

  logic [31:0] imem [64];
  int stall_cycles = 0;
  int stall_left = 0;

  instr_sequencer dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .IMEM_READ(IMEM_READ),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_RDATA(IMEM_RDATA), .INSTRUCTION(INSTRUCTION),
    .WRITEENABLE(WRITEENABLE), .BRAZ(BRAZ), .BRANZ(BRANZ), .BRAUNCOND(BRAUNCOND),
    .ZERO(ZERO), .REG_WRITE_EN(REG_WRITE_EN), .HALTED(HALTED), .ERROR(ERROR),
    .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  // Memory responder: each read stays busy for stall_cycles WAIT cycles.
  assign IMEM_RDATA    = imem[PC[7:2]];
  assign IMEM_BUSYWAIT = IMEM_READ && (stall_left != 0);
  always @(posedge CLK) begin
    if (!IMEM_READ)          stall_left <= stall_cycles;
    else if (stall_left != 0) stall_left <= stall_left - 1;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic set_ctl(input logic we, input logic bz, input logic bnz, input logic bu,
                         input logic z);
    WRITEENABLE = we; BRAZ = bz; BRANZ = bnz; BRAUNCOND = bu; ZERO = z;
  endtask

  // Steps until the retire counter moves or the sequencer halts (bounded).
  task automatic run_instr(output int cyc, output int rd, output int wre);
    logic [15:0] c0;
    c0 = INSTR_COUNT;
    cyc = 0; rd = 0; wre = 0;
    while (INSTR_COUNT === c0 && HALTED !== 1'b1 && cyc < 200) begin
      rd  += int'(IMEM_READ);
      wre += int'(REG_WRITE_EN);
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({PC, IMEM_READ, REG_WRITE_EN, HALTED, ERROR, INSTR_COUNT, INSTRUCTION} !==
        {32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got pc=%h rd=%b wre=%b halt=%b err=%b cnt=%h ir=%h want all zero",
               PC, IMEM_READ, REG_WRITE_EN, HALTED, ERROR, INSTR_COUNT, INSTRUCTION);
    end
  endtask

  task automatic test_add;
    imem[0] = 32'h0012_3456;
    set_ctl(1, 0, 0, 0, 0);
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (REG_WRITE_EN !== (c == 5) || IMEM_READ !== (c == 2)) begin
        errors++;
        $display("FAIL add_cycle%0d: got wre=%b rd=%b want wre=%b rd=%b",
                 c, REG_WRITE_EN, IMEM_READ, c == 5, c == 2);
      end
      tick();
    end
    checks++;
    if (PC !== 32'h4 || INSTR_COUNT !== 16'd1 || INSTRUCTION !== 32'h0012_3456) begin
      errors++;
      $display("FAIL add_retire: got pc=%h cnt=%0d ir=%h want pc=4 cnt=1 ir=00123456",
               PC, INSTR_COUNT, INSTRUCTION);
    end
    imem[0] = 32'h0;
  endtask

  task automatic test_busywait;
    int cyc, rd, wre;
    set_ctl(0, 0, 0, 0, 0);
    do_reset();
    run_instr(cyc, rd, wre);
    run_instr(cyc, rd, wre);
    stall_cycles = 3;
    run_instr(cyc, rd, wre);
    stall_cycles = 0;
    checks++;
    if (cyc !== 8 || rd !== 4 || PC !== 32'hC) begin
      errors++;
      $display("FAIL busywait: got cyc=%0d rd=%0d pc=%h want cyc=8 rd=4 pc=c", cyc, rd, PC);
    end
  endtask

  task automatic test_branch_braz;
    int cyc, rd, wre;
    imem[4] = 32'h9000_0003;
    for (int z = 1; z >= 0; z--) begin
      set_ctl(1, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 4; i++) run_instr(cyc, rd, wre);
      set_ctl(1, 1, 0, 0, logic'(z));
      run_instr(cyc, rd, wre);
      checks++;
      if (PC !== ((z == 1) ? 32'h20 : 32'h14) || wre !== 0 || cyc !== 5) begin
        errors++;
        $display("FAIL braz_zero%0d: got pc=%h wre=%0d cyc=%0d want pc=%h wre=0 cyc=5",
                 z, PC, wre, cyc, (z == 1) ? 32'h20 : 32'h14);
      end
    end
    // BRANZ is the mirror: taken only when ZERO=0.
    set_ctl(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) run_instr(cyc, rd, wre);
    set_ctl(1, 0, 1, 0, 0);
    run_instr(cyc, rd, wre);
    checks++;
    if (PC !== 32'h20 || wre !== 0) begin
      errors++;
      $display("FAIL branz_taken: got pc=%h wre=%0d want pc=20 wre=0", PC, wre);
    end
    imem[4] = 32'h0;
  endtask

  task automatic test_back_to_back;
    int cyc, rd, wre;
    imem[0]  = 32'hB000_000F;
    imem[16] = 32'hB000_00FF;
    set_ctl(0, 0, 0, 1, 0);
    do_reset();
    run_instr(cyc, rd, wre);
    checks++;
    if (PC !== 32'h40 || INSTR_COUNT !== 16'd1) begin
      errors++;
      $display("FAIL uncond_jump: got pc=%h cnt=%0d want pc=40 cnt=1", PC, INSTR_COUNT);
    end
    for (int k = 2; k <= 4; k++) begin
      run_instr(cyc, rd, wre);
      checks++;
      if (PC !== 32'h40 || INSTR_COUNT !== 16'(k) || cyc !== 5) begin
        errors++;
        $display("FAIL self_loop%0d: got pc=%h cnt=%0d cyc=%0d want pc=40 cnt=%0d cyc=5",
                 k, PC, INSTR_COUNT, cyc, k);
      end
    end
    imem[0] = 32'h0;
    imem[16] = 32'h0;
  endtask

  task automatic test_pc_wrap;
    int cyc, rd, wre;
    imem[0] = 32'hB000_00FE;
    set_ctl(0, 0, 0, 1, 0);
    do_reset();
    run_instr(cyc, rd, wre);
    checks++;
    if (PC !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL pc_neg_wrap: got pc=%h want fffffffc", PC);
    end
    set_ctl(0, 0, 0, 0, 0);
    run_instr(cyc, rd, wre);
    checks++;
    if (PC !== 32'h0 || INSTR_COUNT !== 16'd2) begin
      errors++;
      $display("FAIL pc_pos_wrap: got pc=%h cnt=%0d want pc=0 cnt=2", PC, INSTR_COUNT);
    end
    imem[0] = 32'h0;
  endtask

  task automatic test_illegal;
    int cyc, rd, wre;
    imem[0] = 32'hC000_0000;
    set_ctl(1, 0, 0, 0, 0);
    do_reset();
    run_instr(cyc, rd, wre);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (HALTED !== 1'b1 || ERROR !== 2'b01 || PC !== 32'h0 || INSTR_COUNT !== 16'd0 ||
        IMEM_READ !== 1'b0 || REG_WRITE_EN !== 1'b0 || cyc !== 3) begin
      errors++;
      $display("FAIL illegal_op: got halt=%b err=%b pc=%h cnt=%0d rd=%b cyc=%0d want 1 01 0 0 0 3",
               HALTED, ERROR, PC, INSTR_COUNT, IMEM_READ, cyc);
    end
    imem[0] = 32'h0;
  endtask

  task automatic test_timeout;
    int cyc, rd, wre;
    set_ctl(0, 0, 0, 0, 0);
    stall_cycles = 1000;
    do_reset();
    run_instr(cyc, rd, wre);
    checks++;
    if (HALTED !== 1'b1 || ERROR !== 2'b10 || cyc !== 65 || rd !== 64 || IMEM_READ !== 1'b0) begin
      errors++;
      $display("FAIL fetch_timeout: got halt=%b err=%b cyc=%0d rd=%0d rd_now=%b want 1 10 65 64 0",
               HALTED, ERROR, cyc, rd, IMEM_READ);
    end
    // Reset out of HALT clears the error code.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++;
    if (HALTED !== 1'b0 || ERROR !== 2'b00 || PC !== 32'h0 || IMEM_READ !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_halt: got halt=%b err=%b pc=%h rd=%b want 0 00 0 0",
               HALTED, ERROR, PC, IMEM_READ);
    end
    stall_cycles = 0;
  endtask

  task automatic test_reset_midflight;
    int cyc, rd, wre;
    set_ctl(0, 0, 0, 0, 0);
    do_reset();
    run_instr(cyc, rd, wre);
    stall_cycles = 1000;
    tick();
    tick();
    tick();
    checks++;
    if (IMEM_READ !== 1'b1 || PC !== 32'h4) begin
      errors++;
      $display("FAIL midwait_pre: got rd=%b pc=%h want rd=1 pc=4", IMEM_READ, PC);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    stall_cycles = 0;
    checks++;
    if (PC !== 32'h0 || IMEM_READ !== 1'b0 || ERROR !== 2'b00 || INSTR_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_midwait: got pc=%h rd=%b err=%b cnt=%0d want 0 0 00 0",
               PC, IMEM_READ, ERROR, INSTR_COUNT);
    end
    run_instr(cyc, rd, wre);
    checks++;
    if (PC !== 32'h4 || cyc !== 5) begin
      errors++;
      $display("FAIL after_reset_run: got pc=%h cyc=%0d want pc=4 cyc=5", PC, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    test_reset();
    test_add();
    test_busywait();
    test_branch_braz();
    test_back_to_back();
    test_pc_wrap();
    test_illegal();
    test_timeout();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
